// File: rtl/pe_operand_arbiter.sv
// Round-robin arbiter for the PE's shared 32-bit operand path: one-hot grant, 3:1 mux select, valid/ready beat handshake.
// Optional multi-beat grants are enabled by defining ARB_BURST_EN (MAX_BURST caps beats per grant).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant held; gnt 000, sel 11; arbitrates as soon as any req is high
// S_GRANT | one source owns the mux; released on transfer (or burst end) or req drop
module pe_operand_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic [2:0] i_last,
    input  logic       i_out_ready,
    output logic [2:0] o_gnt,
    output logic [1:0] o_sel,
    output logic       o_out_valid,
    output logic       o_busy
);

    typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

    state_t     r_state;
    logic [2:0] r_gnt;
    logic [1:0] r_sel;
    logic [1:0] r_ptr;

    logic [1:0] w_win_sel;
    logic [2:0] w_win_gnt;
    logic       w_any_req;
    logic       w_out_valid;
    logic       w_xfer;
    logic       w_release;

    // r_ptr always equals the granted index while in S_GRANT, so a release
    // arbitrating from r_ptr automatically puts the releasing source last.
    always_comb begin
        w_win_sel = 2'b11;
        case (r_ptr)
            2'd0: begin
                if      (i_req[1]) w_win_sel = 2'd1;
                else if (i_req[2]) w_win_sel = 2'd2;
                else if (i_req[0]) w_win_sel = 2'd0;
            end
            2'd1: begin
                if      (i_req[2]) w_win_sel = 2'd2;
                else if (i_req[0]) w_win_sel = 2'd0;
                else if (i_req[1]) w_win_sel = 2'd1;
            end
            default: begin
                if      (i_req[0]) w_win_sel = 2'd0;
                else if (i_req[1]) w_win_sel = 2'd1;
                else if (i_req[2]) w_win_sel = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_win_gnt = 3'b000;
        case (w_win_sel)
            2'd0:    w_win_gnt = 3'b001;
            2'd1:    w_win_gnt = 3'b010;
            2'd2:    w_win_gnt = 3'b100;
            default: w_win_gnt = 3'b000;
        endcase
    end

    assign w_any_req   = |i_req;
    assign w_out_valid = |(r_gnt & i_req);
    assign w_xfer      = w_out_valid & i_out_ready;

`ifdef ARB_BURST_EN
    localparam logic [7:0] L_MAX_BURST = 8'(MAX_BURST);

    logic [7:0] r_beat_cnt;
    logic [7:0] w_beat_inc;

    assign w_beat_inc = r_beat_cnt + 8'd1;
    assign w_release  = !w_out_valid ||
                        (w_xfer && ((|(r_gnt & i_last)) || (w_beat_inc == L_MAX_BURST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= 8'd0;
        end else if (r_state == S_IDLE || w_release) begin
            r_beat_cnt <= 8'd0;
        end else if (w_xfer) begin
            r_beat_cnt <= w_beat_inc;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{i_last, 32'(MAX_BURST)};
    assign w_release    = !w_out_valid || w_xfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_sel   <= 2'b11;
            r_ptr   <= 2'd2;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_win_gnt;
                        r_sel   <= w_win_sel;
                        r_ptr   <= w_win_sel;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        if (w_any_req) begin
                            r_gnt <= w_win_gnt;
                            r_sel <= w_win_sel;
                            r_ptr <= w_win_sel;
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= 3'b000;
                            r_sel   <= 2'b11;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 3'b000;
                    r_sel   <= 2'b11;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_out_valid = w_out_valid;
    assign o_busy      = (r_state == S_GRANT);

endmodule
